// File: rtl/scale_n_sched.sv
// scale_n_sched: round-robin scheduler that time-shares one temporal
// stochastic bit magnifier among NCH request channels.
//
// A granted channel streams WIN samples (one per cycle) from in[out_ch].
// Every G consecutive samples are OR-collapsed into one magnified bit that
// appears on out with a one-cycle out_vld. A short final group is flushed
// at window end. done pulses with the last out_vld and ones reports how many
// magnified bits were 1 (saturating).
//
// Optional feature (define SCALE_SCHED_ZRUN_EN): adds output zrun, the
// longest run of consecutive zero input samples seen in the window.
// Without the macro there is no zrun port and no zero-run logic.

module scale_n_sched #(
  parameter int NCH  = 4,
  parameter int GW   = 16,
  parameter int WINW = 16,
  parameter int CHW  = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    req,
  input  logic [NCH*GW-1:0] g_in,
  input  logic [WINW-1:0]   win,
  input  logic [NCH-1:0]    in,
  output logic [NCH-1:0]    gnt,
  output logic              busy,
  output logic              out,
  output logic              out_vld,
  output logic [CHW-1:0]    out_ch,
  output logic              done,
  output logic [WINW-1:0]   ones
`ifdef SCALE_SCHED_ZRUN_EN
  ,
  output logic [WINW-1:0]   zrun
`endif
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]      state;
  logic [CHW-1:0]  last;      // most recently granted channel
  logic [GW-1:0]   g_s;       // latched effective gain (never 0)
  logic [WINW-1:0] w_s;       // latched window length
  logic [GW-1:0]   gc;        // sample index within the current group
  logic [WINW-1:0] wc;        // sample index within the window
  logic            acc;       // OR of the samples of the open group
  logic [WINW-1:0] cnt;       // running magnified-ones count of this window

  // Per-channel gain fields split out of the flat bus.
  logic [GW-1:0] g_arr [NCH];

  genvar c;
  generate
    for (c = 0; c < NCH; c++) begin : g_split
      assign g_arr[c] = g_in[c*GW +: GW];
    end
  endgenerate

  // Round-robin arbitration signals.
  logic           sel_found;
  logic [CHW-1:0] sel_ch;
  logic [CHW-1:0] cand;
  logic [NCH-1:0] sel_onehot;
  logic [GW-1:0]  sel_gain;
  logic [GW-1:0]  gain_eff;

  // Datapath signals for the sample being consumed this cycle.
  logic            sample;
  logic            keep;
  logic            last_smp;
  logic            grp_end;
  logic            grp_bit;
  logic [WINW-1:0] cnt_next;
  logic            start_win;
  logic            step;

  // Search upward from last+1 (mod NCH) for the first requesting channel.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves
    // it unassigned, which would otherwise infer a latch.
    sel_found = 1'b0;
    sel_ch    = '0;
    cand      = last;
    for (int i = 0; i < NCH; i++) begin
      cand = (cand == CHW'(NCH - 1)) ? '0 : cand + 1'b1;
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_ch    = cand;
      end
    end
  end

  // Grant vector and effective gain of the winning channel (gain 0 acts as 1).
  always_comb begin
    sel_onehot = NCH'(1) << sel_ch;
    sel_gain   = g_arr[sel_ch];
    gain_eff   = (sel_gain == '0) ? GW'(1) : sel_gain;
  end

  // Group / window bookkeeping for the current RUN sample.
  always_comb begin
    sample    = in[out_ch];
    keep      = req[out_ch];
    last_smp  = (wc == w_s - 1'b1);
    grp_end   = (gc == g_s - 1'b1) || last_smp;
    grp_bit   = acc | sample;
    cnt_next  = (grp_bit && (cnt != '1)) ? cnt + 1'b1 : cnt;
    start_win = (state == S_IDLE) && sel_found;
    step      = (state == S_RUN) && keep;
  end

  // Scheduler FSM, magnifier datapath and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state   <= S_IDLE;
      last    <= CHW'(NCH - 1);
      out_ch  <= '0;
      gnt     <= '0;
      busy    <= 1'b0;
      out     <= 1'b0;
      out_vld <= 1'b0;
      done    <= 1'b0;
      ones    <= '0;
      g_s     <= GW'(1);
      w_s     <= '0;
      gc      <= '0;
      wc      <= '0;
      acc     <= 1'b0;
      cnt     <= '0;
    end else begin
      out     <= 1'b0;
      out_vld <= 1'b0;
      done    <= 1'b0;

      if (start_win) begin
        out_ch <= sel_ch;
        last   <= sel_ch;
        g_s    <= gain_eff;
        w_s    <= win;
        gc     <= '0;
        wc     <= '0;
        acc    <= 1'b0;
        cnt    <= '0;
        if (win == '0) begin
          // Empty window: report completion straight away, never grant.
          done <= 1'b1;
          ones <= '0;
        end else begin
          gnt   <= sel_onehot;
          busy  <= 1'b1;
          state <= S_RUN;
        end
      end else if (state == S_RUN) begin
        if (!keep) begin
          // Requester withdrew: drop the window and the open partial group.
          gnt   <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end else begin
          wc <= wc + 1'b1;
          if (grp_end) begin
            out     <= grp_bit;
            out_vld <= 1'b1;
            cnt     <= cnt_next;
            acc     <= 1'b0;
            gc      <= '0;
          end else begin
            acc <= grp_bit;
            gc  <= gc + 1'b1;
          end
          if (last_smp) begin
            done  <= 1'b1;
            ones  <= cnt_next;
            gnt   <= '0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
      end
    end
  end

`ifdef SCALE_SCHED_ZRUN_EN
  logic [WINW-1:0] zcur;      // length of the zero run ending at the last sample
  logic [WINW-1:0] zmax;      // longest zero run so far in this window
  logic [WINW-1:0] zcur_next;
  logic [WINW-1:0] zmax_next;

  // Extend or break the current zero run with this cycle's sample.
  always_comb begin
    zcur_next = sample ? '0 : zcur + 1'b1;
    zmax_next = (zcur_next > zmax) ? zcur_next : zmax;
  end

  // Zero-run tracking; zrun is published only at window completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zcur <= '0;
      zmax <= '0;
      zrun <= '0;
    end else if (start_win) begin
      zcur <= '0;
      zmax <= '0;
      if (win == '0) begin
        zrun <= '0;
      end
    end else if (step) begin
      zcur <= zcur_next;
      zmax <= zmax_next;
      if (last_smp) begin
        zrun <= zmax_next;
      end
    end
  end
`endif

endmodule

// File: tb/tb_scale_n_sched.sv
// Self-checking bench for scale_n_sched: directed scenarios plus randomized
// windows compared against a window-level reference model.
// Define SCALE_SCHED_ZRUN_EN to also check the zrun output.

module tb_scale_n_sched;

  localparam int NCH  = 4;
  localparam int GW   = 16;
  localparam int WINW = 16;
  localparam int CHW  = $clog2(NCH);

  logic              clk;
  logic              rst_n;
  logic [NCH-1:0]    req;
  logic [NCH*GW-1:0] g_in;
  logic [WINW-1:0]   win;
  logic [NCH-1:0]    in;
  logic [NCH-1:0]    gnt;
  logic              busy;
  logic              out;
  logic              out_vld;
  logic [CHW-1:0]    out_ch;
  logic              done;
  logic [WINW-1:0]   ones;
`ifdef SCALE_SCHED_ZRUN_EN
  logic [WINW-1:0]   zrun;
`endif

  scale_n_sched #(.NCH(NCH), .GW(GW), .WINW(WINW), .CHW(CHW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .g_in    (g_in),
    .win     (win),
    .in      (in),
    .gnt     (gnt),
    .busy    (busy),
    .out     (out),
    .out_vld (out_vld),
    .out_ch  (out_ch),
    .done    (done),
    .ones    (ones)
`ifdef SCALE_SCHED_ZRUN_EN
    ,
    .zrun    (zrun)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference-model state and stimulus description.
  int model_last;
  int model_ones;
  int model_zrun;
  int gains [NCH];
  int win_v;
  bit pat [64];
  bit scramble;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round robin: first requester searching upward from last+1 modulo NCH.
  function automatic int rr_pick(input int lst, input logic [NCH-1:0] r);
    for (int i = 1; i <= NCH; i++) begin
      if (r[(lst + i) % NCH]) return (lst + i) % NCH;
    end
    return -1;
  endfunction

  task automatic check_reset_outputs();
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_out", out, 0);
    check("rst_vld", out_vld, 0);
    check("rst_done", done, 0);
    check("rst_ones", ones, 0);
    check("rst_out_ch", out_ch, 0);
`ifdef SCALE_SCHED_ZRUN_EN
    check("rst_zrun", zrun, 0);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    tick();
    tick();
    check_reset_outputs();
    rst_n      = 1'b1;
    model_last = NCH - 1;
    model_ones = 0;
    model_zrun = 0;
  endtask

  // Serve one window for the channel the arbiter should pick from the current
  // req. Called one cycle before the expected grant. abort_at >= 0 drops all
  // requests once that many samples have been fed.
  task automatic serve(input int abort_at);
    int ch, g, gs, w, ngnt, first_gnt, done_cyc, drop_cyc, nexp, e_ones, e_z, zc;
    bit vld_at_done, b;
    bit exp_q[$];
    bit got_q[$];

    ch = rr_pick(model_last, req);
    model_last = ch;
    g  = gains[ch];
    w  = win_v;
    gs = (g == 0) ? 1 : g;
    for (int c = 0; c < NCH; c++) g_in[c*GW +: GW] = gains[c][GW-1:0];
    win = win_v[WINW-1:0];

    // Expected magnified bits: OR over consecutive groups of gs samples.
    for (int i = 0; i < w; i += gs) begin
      b = 1'b0;
      for (int j = i; j < i + gs && j < w; j++) b |= pat[j];
      exp_q.push_back(b);
    end
    e_ones = 0;
    foreach (exp_q[i]) e_ones += int'(exp_q[i]);
    e_z = 0;
    zc  = 0;
    for (int i = 0; i < w; i++) begin
      zc  = pat[i] ? 0 : zc + 1;
      e_z = (zc > e_z) ? zc : e_z;
    end

    ngnt = 0; first_gnt = -1; done_cyc = -1; drop_cyc = -1; vld_at_done = 0;
    for (int cyc = 1; cyc <= w + 8; cyc++) begin
      tick();
      in = NCH'($urandom);
      if (out_vld) got_q.push_back(out);
      if (gnt != 0) begin
        ngnt++;
        if (first_gnt < 0) begin
          first_gnt = cyc;
          check("gnt_onehot", gnt, 1 << ch);
          check("out_ch", out_ch, ch);
          check("busy_run", busy, 1);
        end
        if (scramble) begin
          win = WINW'($urandom);
          for (int c = 0; c < NCH; c++) g_in[c*GW +: GW] = GW'($urandom);
        end
        if (abort_at >= 0 && ngnt > abort_at) begin
          if (drop_cyc < 0) drop_cyc = cyc;
          req = '0;
        end else if (ngnt <= 64) begin
          in[ch] = pat[ngnt-1];
        end
      end
      if (done) begin
        done_cyc    = cyc;
        vld_at_done = out_vld;
        break;
      end
      if (drop_cyc >= 0 && cyc >= drop_cyc + 3) break;
    end

    if (abort_at >= 0) begin
      nexp = abort_at / gs;
      check("abort_no_done", done_cyc, -1);
      check("abort_ngnt", ngnt, abort_at + 1);
      check("abort_gnt_low", gnt, 0);
      check("abort_busy", busy, 0);
      check("abort_nvld", got_q.size(), nexp);
      check("abort_ones", ones, model_ones);
`ifdef SCALE_SCHED_ZRUN_EN
      check("abort_zrun", zrun, model_zrun);
`endif
    end else begin
      nexp = exp_q.size();
      if (w > 0) begin
        check("gnt_lat", first_gnt, 1);
        check("done_vld", vld_at_done, 1);
      end
      check("done_lat", done_cyc, w + 1);
      check("ngnt", ngnt, w);
      check("nvld", got_q.size(), nexp);
      check("done_gnt", gnt, 0);
      check("done_busy", busy, 0);
      check("ones", ones, e_ones);
      model_ones = e_ones;
      model_zrun = e_z;
`ifdef SCALE_SCHED_ZRUN_EN
      check("zrun", zrun, e_z);
`endif
    end
    for (int i = 0; i < nexp && i < got_q.size(); i++) check("out_bit", got_q[i], exp_q[i]);
  endtask

  task automatic set_pat(input int w, input int ones_at_a, input int ones_at_b);
    for (int i = 0; i < 64; i++) pat[i] = 1'b0;
    if (ones_at_a >= 0) pat[ones_at_a] = 1'b1;
    if (ones_at_b >= 0) pat[ones_at_b] = 1'b1;
    win_v = w;
  endtask

  initial begin
    int r, ab, w;
    n_vec = 0; n_err = 0; scramble = 0;
    rst_n = 1'b0; req = '0; in = '0; win = '0; g_in = '0;
    foreach (gains[i]) gains[i] = 1;
    win_v = 0;
    for (int i = 0; i < 64; i++) pat[i] = 1'b0;
    tick();
    do_reset();

    // G=4, WIN=16, ones at samples 0 and 9 -> 1,0,1,0; ONES=2; ZRUN=8.
    gains[0] = 4; set_pat(16, 0, 9); req = 4'b0001;
    serve(-1); req = '0;

    // G=5, WIN=12, one at sample 11 -> 0,0,1 with a 2-sample final group.
    gains[0] = 5; set_pat(12, 11, -1); req = 4'b0001;
    serve(-1); req = '0;

    // G=0 behaves as G=1: output mirrors 1,0,1,1,0,0,0,0.
    gains[0] = 0; set_pat(8, 0, 2); pat[3] = 1'b1; req = 4'b0001;
    serve(-1); req = '0;

    // Abort after 6 samples with G=4: one group completed, ONES held.
    gains[0] = 4; for (int i = 0; i < 16; i++) pat[i] = 1'b1; win_v = 16; req = 4'b0001;
    serve(6);

    // WIN=0 on channel 2: immediate DONE, ONES=0, no grant.
    set_pat(0, -1, -1); req = 4'b0100;
    serve(-1); req = '0;
    tick();

    // Reset in the middle of a channel-1 window; afterwards channel 0 wins.
    gains[1] = 3; win = 16; g_in[1*GW +: GW] = 16'd3; req = 4'b0010;
    tick(); tick(); tick();
    check("pre_rst_gnt", gnt, 4'b0010);
    rst_n = 1'b0; req = 4'b0101;
    tick();
    check_reset_outputs();
    rst_n = 1'b1; model_last = NCH - 1; model_ones = 0; model_zrun = 0;
    gains[0] = 2; set_pat(6, 1, 4);
    serve(-1);
    check("post_rst_ch", out_ch, 0);
    req = '0;

    // Back-to-back round robin with REQ=1010 held: ch1, ch3, ch1.
    do_reset();
    gains[1] = 2; gains[3] = 3; set_pat(4, 2, -1); req = 4'b1010;
    serve(-1); check("rr_first", out_ch, 1);
    serve(-1); check("rr_second", out_ch, 3);
    serve(-1); check("rr_third", out_ch, 1);
    req = '0;
    tick();

    // Randomized windows, requests, gains, aborts and mid-run input churn.
    scramble = 1;
    for (int t = 0; t < 60; t++) begin
      r = $urandom_range(1, 15);
      for (int c = 0; c < NCH; c++) begin
        case ($urandom_range(0, 5))
          0:       gains[c] = 0;
          1:       gains[c] = $urandom_range(20, 40);
          default: gains[c] = $urandom_range(1, 7);
        endcase
      end
      w = $urandom_range(0, 24);
      win_v = w;
      for (int i = 0; i < 64; i++) pat[i] = ($urandom_range(0, 2) == 0);
      ab = (w >= 2 && $urandom_range(0, 5) == 0) ? $urandom_range(1, w - 1) : -1;
      req = NCH'(r);
      serve(ab);
      req = '0;
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
